// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the CPU-side memory bus controller.
//   - bus widths and legal latency/pulse-width limits
//   - state encoding of the bus sequencer (also exported on the debug port)
package mem_bus_pkg;

  localparam int MEM_ADDR_W    = 16;
  localparam int MEM_DATA_W    = 8;
  localparam int RD_LAT_MAX    = 4;
  localparam int WR_CYCLES_MAX = 4;

  // Width of the per-byte phase counter; holds 0 .. max(RD_LAT_MAX, WR_CYCLES_MAX)-1.
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_io.sv
// mem_bus_io: data-bus pin logic for mem_bus_ctrl.
//   i_drive_en  : 1 = drive io_mem_data with i_out_byte, 0 = release (high-Z)
//   i_out_byte  : byte placed on the bus while driving
//   i_clear     : zero the read capture register (new request accepted)
//   i_capture   : sample io_mem_data this edge
//   i_cap_hi    : 0 = capture into o_rdata[7:0], 1 = into o_rdata[15:8]
//   io_mem_data : shared 8-bit memory data bus
//   o_rdata     : assembled read data (zero for writes)
module mem_bus_io
  import mem_bus_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_drive_en,
  input  logic [MEM_DATA_W-1:0]   i_out_byte,
  input  logic                    i_clear,
  input  logic                    i_capture,
  input  logic                    i_cap_hi,
  inout  wire  [MEM_DATA_W-1:0]   io_mem_data,
  output logic [2*MEM_DATA_W-1:0] o_rdata
);

  logic [2*MEM_DATA_W-1:0] r_rdata;

  assign io_mem_data = i_drive_en ? i_out_byte : {MEM_DATA_W{1'bz}};
  assign o_rdata     = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_clear) begin
      r_rdata <= '0;
    end else if (i_capture) begin
      if (i_cap_hi) r_rdata[2*MEM_DATA_W-1:MEM_DATA_W] <= io_mem_data;
      else          r_rdata[MEM_DATA_W-1:0]            <= io_mem_data;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bus interface unit between the core load/store path and the
// byte-wide memory. One request at a time; each byte goes SETUP -> WRITE/READ,
// and the request finishes with a one-cycle RESP pulse.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so req_valid in any other state is ignored.
// The response (rsp_valid) is a single-cycle pulse with no backpressure.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake
//   req_we, req_word       : write select, 16-bit access select
//   req_addr, req_wdata    : byte address, write data (low byte at req_addr)
//   rsp_valid, rsp_rdata   : completion pulse and read data (0 for writes)
//   mem_addr, mem_cs,
//   mem_we, mem_data       : memory-side address, strobes and shared data bus
//   dbg_state              : current sequencer state
//
// Build option MEM_BUS_WORD_EN: when defined, req_word=1 performs a two-byte
// little-endian access (byte 1 at addr+1, wrapping 0xFFFF -> 0x0000). When
// undefined, req_word is ignored and the NEXT state is not built.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int WR_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic                    req_word,
  input  logic [MEM_ADDR_W-1:0]   req_addr,
  input  logic [2*MEM_DATA_W-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [2*MEM_DATA_W-1:0] rsp_rdata,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  inout  wire  [MEM_DATA_W-1:0]   mem_data,
  output logic                    mem_we,
  output logic                    mem_cs,
  output state_t                  dbg_state
);

  // Last value of the phase counter: SETUP counts as read cycle 0.
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_we;
  logic                    r_word;
  logic                    r_hi;       // working on byte 1 of a word access
  logic [2*MEM_DATA_W-1:0] r_wdata;
  logic [MEM_ADDR_W-1:0]   r_mem_addr;
  logic                    r_cs;
  logic                    r_mwe;
  logic                    r_ready;
  logic                    r_rsp;
  logic                    r_drive;
  logic [MEM_DATA_W-1:0]   r_out_byte;

  logic w_accept;
  logic w_capture;
  logic w_byte_end;
  logic w_more;

  assign w_accept   = req_valid & r_ready;
  // Read data is sampled on the edge that ends the last read cycle.
  assign w_capture  = ((r_state == ST_SETUP) || (r_state == ST_READ)) && !r_we && (r_cnt == RD_LAST);
  assign w_byte_end = w_capture || ((r_state == ST_WRITE) && (r_cnt == WR_LAST));

`ifdef MEM_BUS_WORD_EN
  assign w_more = r_word & ~r_hi;
`else
  logic w_unused;
  assign w_more   = 1'b0;
  assign w_unused = &{1'b0, r_word};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_word     <= 1'b0;
      r_hi       <= 1'b0;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_cs       <= 1'b0;
      r_mwe      <= 1'b0;
      r_ready    <= 1'b1;
      r_rsp      <= 1'b0;
      r_drive    <= 1'b0;
      r_out_byte <= '0;
    end else begin
      r_rsp <= 1'b0;
      if (w_byte_end) begin
        // Byte finished: drop strobes, keep write data on the bus one more cycle.
        r_cs  <= 1'b0;
        r_mwe <= 1'b0;
        r_cnt <= '0;
        if (w_more) begin
          r_hi    <= 1'b1;
          r_state <= ST_NEXT;
        end else begin
          r_rsp   <= 1'b1;
          r_state <= ST_RESP;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_we       <= req_we;
              r_word     <= req_word;
              r_wdata    <= req_wdata;
              r_hi       <= 1'b0;
              r_cnt      <= '0;
              r_mem_addr <= req_addr;
              r_cs       <= 1'b1;
              r_ready    <= 1'b0;
              r_drive    <= req_we;
              r_out_byte <= req_wdata[MEM_DATA_W-1:0];
              r_state    <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (r_we) begin
              // Address has been stable for the SETUP cycle before mem_we rises.
              r_mwe   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_WRITE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= ST_READ;
            end
          end
          ST_READ:  r_cnt <= r_cnt + 1'b1;
          ST_WRITE: r_cnt <= r_cnt + 1'b1;
`ifdef MEM_BUS_WORD_EN
          ST_NEXT: begin
            r_mem_addr <= r_mem_addr + 16'd1;
            r_cs       <= 1'b1;
            r_out_byte <= r_wdata[2*MEM_DATA_W-1:MEM_DATA_W];
            r_state    <= ST_SETUP;
          end
`endif
          ST_RESP: begin
            r_ready <= 1'b1;
            r_drive <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_cs    <= 1'b0;
            r_mwe   <= 1'b0;
            r_drive <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  mem_bus_io u_io (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_drive_en  (r_drive),
    .i_out_byte  (r_out_byte),
    .i_clear     (w_accept),
    .i_capture   (w_capture),
    .i_cap_hi    (r_hi),
    .io_mem_data (mem_data),
    .o_rdata     (rsp_rdata)
  );

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp;
  assign mem_addr  = r_mem_addr;
  assign mem_cs    = r_cs;
  assign mem_we    = r_mwe;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: byte-wide memory model on the shared bus,
// table of directed requests, reset-abort and held-valid sequences, then
// randomized requests checked against a flat reference memory image.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int RD_LAT    = 3;
  localparam int WR_CYCLES = 2;
`ifdef MEM_BUS_WORD_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_word = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr;
  tri1  [7:0]  mem_data;   // released bus reads back as 0xFF
  logic        mem_we;
  logic        mem_cs;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  mem_bus_ctrl #(.RD_LAT(RD_LAT), .WR_CYCLES(WR_CYCLES)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_cs    (mem_cs),
    .dbg_state (dbg_state)
  );

  // ---------------- memory device model ----------------
  logic [7:0] mem [0:65535];
  logic       mem_clr = 1'b1;
  logic       tb_rd_op = 1'b0;  // memory output enable for the current request

  assign mem_data = (mem_cs && !mem_we && tb_rd_op) ? mem[mem_addr] : 8'hzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 65536; a++) mem[a] <= 8'h00;
    end else if (mem_cs && mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:65535];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, observe it cycle by cycle, and compare against the
  // reference image and the latency rules.
  task automatic do_req(input logic we, input logic word, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata);
    int nbytes, busy, exp_lat, lat, we_cnt, we_first, k;
    logic [15:0] exp_rd;
    logic [15:0] prev_addr;
    logic prev_we, ready_bad, addr_bad;
    logic [7:0] exp_bus;
    nbytes  = (WORD_EN && word) ? 2 : 1;
    busy    = we ? WR_CYCLES + 1 : RD_LAT;
    exp_lat = nbytes * (busy + 1);
    exp_rd  = '0;
    if (!we)
      for (int b = 0; b < nbytes; b++) exp_rd[8*b +: 8] = ref_mem[16'(addr + 16'(b))];
    exp_bus = (nbytes == 2) ? wdata[15:8] : wdata[7:0];

    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    tb_rd_op  = !we;
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wdata;
    prev_addr = mem_addr; prev_we = mem_we;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_word = 1'($urandom);
    req_addr = 16'($urandom); req_wdata = 16'($urandom);

    lat = 0; we_cnt = 0; we_first = 0; ready_bad = 1'b0; addr_bad = 1'b0; rdata = 16'hDEAD;
    for (k = 1; k <= 64 && lat == 0; k++) begin
      if (mem_we && !prev_we && mem_addr != prev_addr) addr_bad = 1'b1;
      if (mem_we) begin
        we_cnt++;
        if (we_first == 0) we_first = k;
      end
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        if (we) check("wr_bus_hold", {24'd0, mem_data}, {24'd0, exp_bus});
        else    check("rd_bus_released", {24'd0, mem_data}, 32'h0000_00FF);
      end else if (req_ready) begin
        ready_bad = 1'b1;
      end
      prev_addr = mem_addr; prev_we = mem_we;
      @(negedge clk);
    end

    check("latency", lat, exp_lat);
    check("ready_low_busy", {31'd0, ready_bad}, 32'd0);
    check("we_addr_stable", {31'd0, addr_bad}, 32'd0);
    check("we_cycles", we_cnt, we ? nbytes * WR_CYCLES : 0);
    if (we) check("we_first_cycle", we_first, 32'd2);
    check("rsp_rdata", {16'd0, rdata}, {16'd0, exp_rd});
    check("idle_after_rsp", {30'd0, req_ready, rsp_valid}, 32'd2);

    if (we)
      for (int b = 0; b < nbytes; b++) ref_mem[16'(addr + 16'(b))] = wdata[8*b +: 8];
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] rd;
    int acc, rsps, mism;

    for (int a = 0; a < 65536; a++) ref_mem[a] = 8'h00;

    vecs[0] = '{1'b1, 1'b0, 16'h0001, 16'h00FF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h00FF};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hA55A, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, WORD_EN ? 16'hA55A : 16'h005A};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, WORD_EN ? 16'h00A5 : 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0034};

    // ---- reset values ----
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_data_z", {24'd0, mem_data}, 32'h0000_00FF);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- directed table ----
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("table_rdata[%0d]", i), {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
    end
    check("mem_0001", {24'd0, mem[16'h0001]}, 32'h0000_00FF);
    check("mem_FFFF", {24'd0, mem[16'hFFFF]}, 32'h0000_005A);
    check("mem_0000", {24'd0, mem[16'h0000]}, WORD_EN ? 32'h0000_00A5 : 32'h0000_0000);
    check("mem_0011_word_ignored", {24'd0, mem[16'h0011]}, 32'h0000_0000);

    // ---- reset during WRITE ----
    tb_rd_op = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_word = 1'b0; req_addr = 16'h0040; req_wdata = 16'h003C;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_we_on", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we_drop", {31'd0, mem_we}, 32'd0);
    check("abort_cs_drop", {31'd0, mem_cs}, 32'd0);
    check("abort_bus_z", {24'd0, mem_data}, 32'h0000_00FF);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsps = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    check("abort_no_rsp", rsps, 32'd0);
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    check("abort_mem_untouched", {24'd0, mem[16'h0040]}, 32'h0000_0000);

    // ---- req_valid held high: accepts only in IDLE ----
    tb_rd_op = 1'b1;
    req_we = 1'b0; req_word = 1'b0; req_addr = 16'h0001; req_valid = 1'b1;
    acc = 0; rsps = 0;
    for (int c = 0; c < 40; c++) begin
      if (req_ready) acc++;
      if (rsp_valid) begin
        rsps++;
        check("held_rdata", {16'd0, rsp_rdata}, {24'd0, ref_mem[16'h0001]});
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) begin
        rsps++;
        check("held_rdata", {16'd0, rsp_rdata}, {24'd0, ref_mem[16'h0001]});
      end
      @(negedge clk);
    end
    check("held_accepts", acc, (40 + RD_LAT + 1) / (RD_LAT + 2));
    check("held_one_rsp_per_accept", rsps, acc);

    // ---- randomized requests ----
    for (int i = 0; i < 150; i++) begin
      int pick;
      logic [15:0] a;
      pick = $urandom_range(0, 9);
      a = (pick < 8) ? 16'(pick) : ((pick == 8) ? 16'hFFFF : 16'hFFFE);
      do_req(1'($urandom), 1'($urandom), a, 16'($urandom), rd);
    end

    mism = 0;
    for (int a = 0; a < 64; a++) if (mem[a] !== ref_mem[a]) mism++;
    for (int a = 16'hFFF0; a < 65536; a++) if (mem[a] !== ref_mem[a]) mism++;
    check("mem_image", mism, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Bus interface unit between the CPU core's load/store path and the byte-wide `memory` block. Accepts single read/write requests over a valid/ready handshake, sequences `mem_cs`/`mem_we`/`mem_addr`, drives or tristates the shared 8-bit data bus, captures read data and returns one response pulse per request. Optional 16-bit word accesses are split into two byte cycles.

## Interface
- `RD_LAT`, 1, cycles from address presented to read data sampled (legal 1..4)
- `WR_CYCLES`, 1, width of `mem_we` pulse in cycles (legal 1..4)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; high only in IDLE
- `req_we`  in  1  1 = write, 0 = read
- `req_word`  in  1  1 = 16-bit access (ignored unless `MEM_BUS_WORD_EN`)
- `req_addr`  in  16  byte address
- `req_wdata`  in  16  write data; low byte at `req_addr`
- `rsp_valid`  out  1  one-cycle completion pulse (reads and writes)
- `rsp_rdata`  out  16  read data, valid with `rsp_valid`; 0 for writes
- `mem_addr`  out  16  memory address
- `mem_data`  inout  8  shared data bus
- `mem_we`  out  1  memory write enable
- `mem_cs`  out  1  memory chip select

## Operation
- Accept on `req_valid && req_ready`; addr, we, word, wdata latched that edge.
- States: IDLE, SETUP, WRITE, READ, NEXT, RESP.
- IDLE -> SETUP on accept. SETUP (1 cycle): `mem_cs`=1, `mem_addr` valid, `mem_we`=0; write data driven if write.
- Write: SETUP -> WRITE for `WR_CYCLES` cycles, `mem_we`=1, data held -> NEXT/RESP.
- Read: SETUP -> READ for `RD_LAT`-1 further cycles (0 if `RD_LAT`=1); `mem_data` sampled on the edge ending the last read cycle (SETUP counts as cycle 1).
- Word: after byte 0, NEXT (1 cycle, `mem_cs`=0, `mem_we`=0) then SETUP at addr+1 for byte 1; addr+1 wraps 0xFFFF -> 0x0000.
- RESP (1 cycle): `rsp_valid`=1, `mem_cs`=0, `mem_we`=0 -> IDLE. No response backpressure.
- Bus ownership: `mem_data` driven only in SETUP/WRITE of a write and in the following NEXT/RESP cycle (hold); high-Z otherwise. Never driven while reading.
- `req_valid` outside IDLE is ignored (not accepted).

## Timing
- Reset values (held while `rst_n`=0): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `mem_cs`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=Z.
- Byte read latency: accept at cycle 0, `rsp_valid` at cycle `RD_LAT`+1; next accept at `RD_LAT`+2.
- Byte write latency: `rsp_valid` at cycle `WR_CYCLES`+2.
- Word: byte latency doubled plus 1 NEXT cycle, minus one RESP.
- `mem_we` never rises in the same cycle `mem_addr` changes; address stable ≥1 cycle before and during `mem_we`.
- Reset asserted mid-access: outputs go to reset values asynchronously; write pulse truncated; no `rsp_valid` for the aborted request.

## Configuration
- `MEM_BUS_WORD_EN` defined: `req_word`=1 performs two-byte little-endian access; `rsp_rdata` = {byte@addr+1, byte@addr}.
- Undefined: `req_word` ignored, all accesses single-byte, `rsp_rdata[15:8]`=0, `req_wdata[15:8]` unused, NEXT state not built.

## Structure
- Package `mem_bus_pkg`: state encoding, `MEM_ADDR_W`=16, `MEM_DATA_W`=8, `RD_LAT_MAX`/`WR_CYCLES_MAX`=4.
- Sub-module `mem_bus_io`: tristate driver for `mem_data` (drive enable + out byte) and read capture register; FSM/counters stay in `mem_bus_ctrl`.

## Test plan
- Byte write 0xFF to 0x0001, RD_LAT=1/WR_CYCLES=1 -> `mem_we` high exactly cycle 2, `rsp_valid` cycle 3, memory[0x0001]=0xFF.
- Byte read 0x0001 after above -> `rsp_rdata`=0x00FF at cycle 2; `mem_data` never driven by controller during read.
- RD_LAT=3 read of 0x0020 holding 0x00 -> `rsp_valid` at cycle 4, `rsp_rdata`=0x0000; `req_ready`=0 cycles 1..4.
- `MEM_BUS_WORD_EN`: write 0xA55A at 0xFFFF, read back -> memory[0xFFFF]=0x5A, memory[0x0000]=0xA5, `rsp_rdata`=0xA55A.
- `rst_n` low during WRITE -> `mem_we`, `mem_cs` drop same cycle, `mem_data`=Z, no `rsp_valid`, `req_ready`=1 after release.
- `req_valid` held high continuously -> back-to-back requests accepted only in IDLE, exactly one `rsp_valid` per accept.
